// File: rtl/alarm_pkg.sv
// Shared definitions for the alarm timekeeper: BCD limits, load-target
// encoding and the two-digit BCD helper functions.
package alarm_pkg;

    // Highest legal hours value (BCD)
    localparam logic [7:0] HH_MAX = 8'h23;
    // Highest legal minutes/seconds value (BCD)
    localparam logic [7:0] MS_MAX = 8'h59;

    // Meaning of set_sel
    typedef enum logic {
        SET_TIME  = 1'b0,
        SET_ALARM = 1'b1
    } set_sel_e;

    // True when both nibbles are decimal digits and the value is within max
    function automatic logic bcd_valid(input logic [7:0] v, input logic [7:0] max);
        return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) && (v <= max);
    endfunction

    // Two-digit BCD increment that wraps to 00 after max
    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max);
        if (v == max) begin
            return 8'h00;
        end else if (v[3:0] == 4'd9) begin
            return {v[7:4] + 4'd1, 4'h0};
        end else begin
            return {v[7:4], v[3:0] + 4'd1};
        end
    endfunction

endpackage

// File: rtl/bcd_counter.sv
// Two-digit BCD counter with a configurable wrap value, synchronous load
// (load beats increment) and a carry-out asserted on the wrapping increment.
// The next value is exported so the parent can compare against it before
// the edge.
module bcd_counter
    import alarm_pkg::*;
#(
    parameter logic [7:0] MAX = 8'h59
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_inc,
    input  logic       i_load,
    input  logic [7:0] i_load_val,
    output logic [7:0] o_q,
    output logic [7:0] o_q_next,
    output logic       o_carry
);

    logic [7:0] r_q;
    logic [7:0] w_q_next;

    // Next-value selection: load has priority over increment
    always_comb begin
        w_q_next = r_q;
        if (i_load) begin
            w_q_next = i_load_val;
        end else if (i_inc) begin
            w_q_next = bcd_inc(r_q, MAX);
        end
    end

    // Counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= 8'h00;
        end else begin
            r_q <= w_q_next;
        end
    end

    assign o_q      = r_q;
    assign o_q_next = w_q_next;
    assign o_carry  = i_inc && !i_load && (r_q == MAX);

endmodule

// File: rtl/alarm_timekeeper.sv
// 24-hour BCD timekeeper with an alarm-match pulse.
// A prescaler produces one sec_tick every CLKS_PER_SEC cycles; three BCD
// counters chain ss -> mm -> hh. H is raised for the single cycle in which
// the outputs first show the alarm time with ss == 00. Loads are validated;
// a rejected load changes nothing and raises set_err for one cycle.
module alarm_timekeeper
    import alarm_pkg::*;
#(
    parameter int unsigned CLKS_PER_SEC = 10000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       alarm_on,
    input  logic       set_en,
    input  logic       set_sel,
    input  logic [7:0] set_hh,
    input  logic [7:0] set_mm,
    output logic [7:0] hh,
    output logic [7:0] mm,
    output logic [7:0] ss,
    output logic       H,
    output logic       set_err
);

    localparam int unsigned PW = $clog2(CLKS_PER_SEC);
    localparam logic [PW-1:0] PRESC_LAST = PW'(CLKS_PER_SEC - 1);

    logic [PW-1:0] r_presc;
    logic [7:0]    r_alarm_hh;
    logic [7:0]    r_alarm_mm;
    logic          r_H;
    logic          r_set_err;

    logic       w_sec_tick;
    logic       w_tick;
    logic       w_set_valid;
    logic       w_load_time;
    logic       w_load_alarm;
    logic       w_match;
    set_sel_e   w_sel;

    logic [7:0] w_ss_q, w_mm_q, w_hh_q;
    logic [7:0] w_ss_next, w_mm_next, w_hh_next;
    logic       w_ss_carry, w_mm_carry;
    // Day rollover out of the hours digit has no consumer
    logic       w_unused_day_carry;

    assign w_sel        = set_sel_e'(set_sel);
    assign w_sec_tick   = (r_presc == PRESC_LAST);
    assign w_set_valid  = bcd_valid(set_hh, HH_MAX) && bcd_valid(set_mm, MS_MAX);
    assign w_load_time  = set_en && w_set_valid && (w_sel == SET_TIME);
    assign w_load_alarm = set_en && w_set_valid && (w_sel == SET_ALARM);
    // A time load discards a coincident tick
    assign w_tick       = w_sec_tick && !w_load_time;

    // Match against the time about to be shown; the alarm registers still
    // hold their pre-load value here, so a coincident alarm load is ignored.
    assign w_match = w_tick && alarm_on &&
                     (w_ss_next == 8'h00) &&
                     (w_mm_next == r_alarm_mm) &&
                     (w_hh_next == r_alarm_hh);

    // Prescaler: restarts after reset, after a time load, and after each tick
    always_ff @(posedge clk) begin
        if (rst) begin
            r_presc <= '0;
        end else if (w_load_time || w_sec_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + PW'(1);
        end
    end

    bcd_counter #(.MAX(MS_MAX)) u_ss (
        .clk        (clk),
        .rst        (rst),
        .i_inc      (w_tick),
        .i_load     (w_load_time),
        .i_load_val (8'h00),
        .o_q        (w_ss_q),
        .o_q_next   (w_ss_next),
        .o_carry    (w_ss_carry)
    );

    bcd_counter #(.MAX(MS_MAX)) u_mm (
        .clk        (clk),
        .rst        (rst),
        .i_inc      (w_ss_carry),
        .i_load     (w_load_time),
        .i_load_val (set_mm),
        .o_q        (w_mm_q),
        .o_q_next   (w_mm_next),
        .o_carry    (w_mm_carry)
    );

    bcd_counter #(.MAX(HH_MAX)) u_hh (
        .clk        (clk),
        .rst        (rst),
        .i_inc      (w_mm_carry),
        .i_load     (w_load_time),
        .i_load_val (set_hh),
        .o_q        (w_hh_q),
        .o_q_next   (w_hh_next),
        .o_carry    (w_unused_day_carry)
    );

    // Alarm time registers, written only by a valid alarm load
    always_ff @(posedge clk) begin
        if (rst) begin
            r_alarm_hh <= 8'h00;
            r_alarm_mm <= 8'h00;
        end else if (w_load_alarm) begin
            r_alarm_hh <= set_hh;
            r_alarm_mm <= set_mm;
        end
    end

    // One-cycle H and set_err pulses, aligned with the updated outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_H       <= 1'b0;
            r_set_err <= 1'b0;
        end else begin
            r_H       <= w_match;
            r_set_err <= set_en && !w_set_valid;
        end
    end

    assign hh      = w_hh_q;
    assign mm      = w_mm_q;
    assign ss      = w_ss_q;
    assign H       = r_H;
    assign set_err = r_set_err;

endmodule

// File: doc/alarm_timekeeper.md
ALARM_TIMEKEEPER -- requirements
Module: alarm_timekeeper

Interface
REQ-001 Parameter CLKS_PER_SEC, default 10000000: clk cycles per second; legal range 2..2^24.
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 alarm_on  input  1  arms match detection; 0 suppresses H.
REQ-005 set_en  input  1  one-cycle load strobe.
REQ-006 set_sel  input  1  load target: 0 = current time, 1 = alarm time.
REQ-007 set_hh  input  8  BCD hours to load, 00-23.
REQ-008 set_mm  input  8  BCD minutes to load, 00-59.
REQ-009 hh  output  8  current hours, BCD.
REQ-010 mm  output  8  current minutes, BCD.
REQ-011 ss  output  8  current seconds, BCD.
REQ-012 H  output  1  one-cycle alarm-match pulse, consumed by the alarm FSM as its hour-match input.
REQ-013 set_err  output  1  one-cycle pulse flagging a rejected load.

Function
REQ-014 Prescaler SHALL count 0..CLKS_PER_SEC-1, wrap to 0, and assert an internal sec_tick on the cycle the count equals CLKS_PER_SEC-1.
REQ-015 On sec_tick, ss SHALL increment in BCD; 59 wraps to 00 with carry to mm.
REQ-016 mm SHALL increment on carry; 59 wraps to 00 with carry to hh.
REQ-017 hh SHALL increment on carry; 23 wraps to 00, so 23:59:59 -> 00:00:00 on a single tick.
REQ-018 Updated hh/mm/ss SHALL be visible on the outputs the cycle after the sec_tick cycle (one-cycle latency).
REQ-019 H SHALL pulse high for exactly one cycle, coincident with the outputs first showing hh==alarm_hh, mm==alarm_mm, ss==00, and only if alarm_on==1 on the sec_tick cycle.
REQ-020 H SHALL NOT assert from a load: setting time or alarm equal to the current time produces no H.
REQ-021 A load SHALL be valid only if set_hh is legal BCD 00-23 and set_mm is legal BCD 00-59 (each nibble <= 9).
REQ-022 Valid load with set_sel=0 SHALL set hh=set_hh, mm=set_mm, ss=00 and clear the prescaler on the next cycle.
REQ-023 Valid load with set_sel=1 SHALL update alarm_hh/alarm_mm only; current time and prescaler continue counting.
REQ-024 Invalid load SHALL change no state and SHALL pulse set_err for one cycle on the following cycle.
REQ-025 Time load coincident with sec_tick: the load wins, the tick is discarded, and H is suppressed for that cycle.
REQ-026 Alarm load coincident with a matching sec_tick: the comparison SHALL use the pre-load alarm value.
REQ-027 alarm_on falling while H is high SHALL NOT truncate the pulse already issued.

Reset
REQ-028 While rst is sampled high: prescaler=0, hh=mm=ss=8'h00, alarm_hh=alarm_mm=8'h00, H=0, set_err=0.
REQ-029 rst SHALL override set_en and sec_tick in the same cycle; a reset mid-count discards the partial second.
REQ-030 After rst deasserts, the first sec_tick SHALL occur CLKS_PER_SEC cycles later.

Structure
REQ-031 Shared package alarm_pkg SHALL hold the BCD limits (HH_MAX=8'h23, MS_MAX=8'h59) and the SET_TIME/SET_ALARM encodings of set_sel.
REQ-032 One sub-module, bcd_counter, SHALL provide a parameterised-max two-digit BCD counter with inc, load, carry-out, and synchronous reset; it is instantiated three times (ss, mm, hh).
REQ-033 Match compare, load validation, and the H/set_err registers SHALL reside in alarm_timekeeper; all outputs are registered.

Verification (CLKS_PER_SEC=4)
REQ-034 Reset, then run 8 cycles -> ss=01 after cycle 4 and ss=02 after cycle 8; H=0 throughout.
REQ-035 Load time 23:59, wait 60 s -> hh:mm:ss reads 00:00:00 on one cycle with no intermediate illegal values.
REQ-036 alarm_on=1, alarm 07:30, time 07:29, run 60 s -> H is high exactly one cycle, aligned with outputs 07:30:00; H does not fire again during the following 59 s.
REQ-037 Same as REQ-036 with alarm_on=0 -> H never asserts; then set alarm 07:30 while the time is already 07:30:05 -> no H.
REQ-038 Load set_hh=8'h24 or set_mm=8'h5A -> set_err pulses one cycle, time and alarm unchanged.
REQ-039 Assert rst at ss=03 mid-prescale, and separately set_en(time) on a sec_tick cycle -> all outputs zero next cycle after rst; the load value is shown with ss=00 and no extra increment.
